// File: rtl/noise_pkg.sv
`default_nettype none
// ============================================================================
// Package     : noise_pkg
// Description : Shared state encoding, field widths and the noise-channel
//               period table (index 0 = highest pitch, 15 = lowest).
// Revision    : 1.0 - initial release
// ============================================================================
package noise_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_PLAY    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   localparam int PERIOD_W     = 32;
   localparam int PERIOD_IDX_W = 4;
   localparam int VOLUME_W     = 4;
   localparam int LENGTH_W     = 6;
   localparam int ID_W         = 2;
   localparam int ENV_SHIFT    = 5;
   localparam int ENV_W        = 9;

   // Phase increments, roughly geometric from highest to lowest pitch.
   localparam logic [0:15][PERIOD_W-1:0] PERIOD_TABLE = {
      32'h0E517467, 32'h0A5A3B2C, 32'h077C1E90, 32'h056A8F14,
      32'h03EC51D8, 32'h02D6A3B0, 32'h020E4C6A, 32'h017D2F40,
      32'h01144E92, 32'h00C82D6C, 32'h00910A3E, 32'h0068F1B4,
      32'h004C0E7A, 32'h00370BD2, 32'h0027D8E6, 32'h001CD5FA
   };

   // Envelope amplitude is the 4-bit volume scaled into a 9-bit range.
   function automatic logic [ENV_W-1:0] volume_to_envelope(input logic [VOLUME_W-1:0] vol);
      return ENV_W'(vol) << ENV_SHIFT;
   endfunction

endpackage
`default_nettype wire

// File: rtl/noise_channel_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : noise_channel_arbiter_if
// Description : Request/grant bus and channel outputs of the noise arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface noise_channel_arbiter_if
   import noise_pkg::*;
#(
   parameter int NUM_REQ = 4
);
   logic                          i_tick_stb;
   logic                          i_note_stb;
   logic [NUM_REQ-1:0]            i_req;
   logic [PERIOD_IDX_W*NUM_REQ-1:0] i_req_period;
   logic [VOLUME_W*NUM_REQ-1:0]   i_req_volume;
   logic [LENGTH_W*NUM_REQ-1:0]   i_req_length;
   logic [NUM_REQ-1:0]            i_req_mode;

   logic [NUM_REQ-1:0]            o_ack;
   logic [ID_W-1:0]               o_active_id;
   logic                          o_busy;
   logic                          o_done;
   logic                          o_preempt;
   logic [PERIOD_W-1:0]           o_phase_delta;
   logic                          o_phase_delta_valid;
   logic                          o_mode;
   logic [ENV_W-1:0]              o_envelope;

   modport master (
      output i_tick_stb, i_note_stb, i_req, i_req_period, i_req_volume,
             i_req_length, i_req_mode,
      input  o_ack, o_active_id, o_busy, o_done, o_preempt, o_phase_delta,
             o_phase_delta_valid, o_mode, o_envelope
   );

   modport slave (
      input  i_tick_stb, i_note_stb, i_req, i_req_period, i_req_volume,
             i_req_length, i_req_mode,
      output o_ack, o_active_id, o_busy, o_done, o_preempt, o_phase_delta,
             o_phase_delta_valid, o_mode, o_envelope
   );
endinterface
`default_nettype wire

// File: rtl/noise_period_rom.sv
`default_nettype none
// ============================================================================
// Module      : noise_period_rom
// Description : Registered 16x32 period lookup, one cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module noise_period_rom
   import noise_pkg::*;
(
   input  wire logic                    clk,
   input  wire logic                    rst,
   input  wire logic [PERIOD_IDX_W-1:0] addr,
   output logic      [PERIOD_W-1:0]     data
);

   // Registered table read.
   always_ff @(posedge clk) begin
      if (rst) data <= '0;
      else     data <= PERIOD_TABLE[addr];
   end

endmodule
`default_nettype wire

// File: rtl/noise_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : noise_channel_arbiter
// Description : Fixed-priority arbiter for a single noise channel with
//               preemption, envelope decay and note-length timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module noise_channel_arbiter
   import noise_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DECAY_TICKS = 4
)(
   input  wire logic                i_clk,
   input  wire logic                i_reset,
   noise_channel_arbiter_if.slave   bus
);

   localparam int DIV_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_TICKS - 1);

   state_t                  state, next_state;
   logic                    grant_any;
   logic [ID_W-1:0]         grant_idx;
   logic                    preempt_hit;
   logic                    play_done;
   logic                    load_new;
   logic                    done_pulse;
   logic                    preempt_pulse;

   logic [PERIOD_IDX_W-1:0] period_idx;
   logic [VOLUME_W-1:0]     volume;
   logic [LENGTH_W-1:0]     length;
   logic                    length_limited;
   logic                    mode;
   logic [ID_W-1:0]         active_id;
   logic [DIV_W-1:0]        divider;
   logic [PERIOD_W-1:0]     rom_word;

   // Lowest set request index wins; scan from the top so index 0 lands last.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.i_req[i]) begin
            grant_any = 1'b1;
            grant_idx = ID_W'(i);
         end
      end
   end

   assign preempt_hit = grant_any && (grant_idx < active_id);
   assign play_done   = (volume == '0) || (length_limited && (length == '0));

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= next_state;
   end

   // Next-state and pulse decode; preemption outranks completion, reset masks all.
   always_comb begin
      next_state    = state;
      load_new      = 1'b0;
      done_pulse    = 1'b0;
      preempt_pulse = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grant_any) begin
               load_new   = 1'b1;
               next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (preempt_hit) begin
               load_new      = 1'b1;
               preempt_pulse = 1'b1;
               next_state    = ST_LOAD;
            end else begin
               next_state = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (preempt_hit) begin
               load_new      = 1'b1;
               preempt_pulse = 1'b1;
               next_state    = ST_LOAD;
            end else if (play_done) begin
               next_state = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            done_pulse = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
      if (i_reset) begin
         next_state    = ST_IDLE;
         load_new      = 1'b0;
         done_pulse    = 1'b0;
         preempt_pulse = 1'b0;
      end
   end

   // Latch the granted requester's fields, then run decay and length counters in PLAY.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         period_idx     <= '0;
         volume         <= '0;
         length         <= '0;
         length_limited <= 1'b0;
         mode           <= 1'b0;
         active_id      <= '0;
         divider        <= '0;
      end else if (load_new) begin
         period_idx     <= bus.i_req_period[grant_idx*PERIOD_IDX_W +: PERIOD_IDX_W];
         volume         <= bus.i_req_volume[grant_idx*VOLUME_W +: VOLUME_W];
         length         <= bus.i_req_length[grant_idx*LENGTH_W +: LENGTH_W];
         length_limited <= (bus.i_req_length[grant_idx*LENGTH_W +: LENGTH_W] != '0);
         mode           <= bus.i_req_mode[grant_idx];
         active_id      <= grant_idx;
         divider        <= '0;
      end else if (state == ST_PLAY) begin
         if (bus.i_tick_stb) begin
            if (divider == DIV_LAST) begin
               divider <= '0;
               if (volume != '0) volume <= volume - VOLUME_W'(1);
            end else begin
               divider <= divider + DIV_W'(1);
            end
         end
         if (bus.i_note_stb && (length != '0)) begin
            length <= length - LENGTH_W'(1);
         end
      end
   end

   // Period index is latched at grant, so the ROM word is ready on entry to PLAY.
   noise_period_rom u_period_rom (
      .clk  (i_clk),
      .rst  (i_reset),
      .addr (period_idx),
      .data (rom_word)
   );

   assign bus.o_ack               = load_new ? (NUM_REQ'(1) << grant_idx) : '0;
   assign bus.o_active_id         = active_id;
   assign bus.o_busy              = (state == ST_LOAD) || (state == ST_PLAY);
   assign bus.o_done              = done_pulse;
   assign bus.o_preempt           = preempt_pulse;
   assign bus.o_phase_delta       = (state == ST_PLAY) ? rom_word : '0;
   assign bus.o_phase_delta_valid = (state == ST_PLAY);
   assign bus.o_mode              = (state == ST_PLAY) ? mode : 1'b0;
   assign bus.o_envelope          = (state == ST_PLAY) ? volume_to_envelope(volume) : '0;

endmodule
`default_nettype wire

// File: tb/tb_noise_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_noise_channel_arbiter
// Description : Directed self-checking bench for noise_channel_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noise_channel_arbiter;

   localparam int NUM_REQ = 4;

   logic clk = 1'b0;
   logic rst;
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   done_count;

   noise_channel_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   noise_channel_arbiter #(.NUM_REQ(NUM_REQ), .DECAY_TICKS(4)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input int idx, input logic [3:0] per, input logic [3:0] vol,
                             input logic [5:0] len, input logic md);
      bus.i_req_period[idx*4 +: 4] = per;
      bus.i_req_volume[idx*4 +: 4] = vol;
      bus.i_req_length[idx*6 +: 6] = len;
      bus.i_req_mode[idx]          = md;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst              = 1'b1;
      bus.i_tick_stb   = 1'b0;
      bus.i_note_stb   = 1'b0;
      bus.i_req        = 4'b0001;
      bus.i_req_period = '0;
      bus.i_req_volume = '0;
      bus.i_req_length = '0;
      bus.i_req_mode   = '0;
      repeat (2) next_cycle();
      @(negedge clk);
      check("rst_ack",     32'(bus.o_ack), 32'h0);
      check("rst_busy",    32'(bus.o_busy), 32'h0);
      check("rst_env",     32'(bus.o_envelope), 32'h0);
      check("rst_phase",   bus.o_phase_delta, 32'h0);
      check("rst_valid",   32'(bus.o_phase_delta_valid), 32'h0);
      check("rst_id",      32'(bus.o_active_id), 32'h0);
      check("rst_mode",    32'(bus.o_mode), 32'h0);

      // Basic grant, play and length completion
      next_cycle(); rst = 1'b0; bus.i_req = 4'b0100; set_fields(2, 4'd0, 4'd3, 6'd2, 1'b1);
      @(negedge clk); check("t1_ack", 32'(bus.o_ack), 32'h4);
      check("t1_idle_busy", 32'(bus.o_busy), 32'h0);
      next_cycle(); bus.i_req = 4'b0000;
      @(negedge clk); check("t1_load_ack", 32'(bus.o_ack), 32'h0);
      check("t1_load_valid", 32'(bus.o_phase_delta_valid), 32'h0);
      check("t1_load_id", 32'(bus.o_active_id), 32'h2);
      next_cycle();
      @(negedge clk); check("t1_phase", bus.o_phase_delta, 32'h0E517467);
      check("t1_valid", 32'(bus.o_phase_delta_valid), 32'h1);
      check("t1_env", 32'(bus.o_envelope), 32'd96);
      check("t1_mode", 32'(bus.o_mode), 32'h1);
      next_cycle(); bus.i_note_stb = 1'b1;
      next_cycle(); bus.i_note_stb = 1'b1;
      next_cycle(); bus.i_note_stb = 1'b0;
      @(negedge clk); check("t1_len0_done", 32'(bus.o_done), 32'h0);
      next_cycle();
      @(negedge clk); check("t1_done", 32'(bus.o_done), 32'h1);
      check("t1_rel_env", 32'(bus.o_envelope), 32'h0);
      check("t1_rel_valid", 32'(bus.o_phase_delta_valid), 32'h0);
      next_cycle();
      @(negedge clk); check("t1_done_after", 32'(bus.o_done), 32'h0);

      // Envelope decay with unlimited length
      next_cycle(); bus.i_req = 4'b0010; set_fields(1, 4'd15, 4'd2, 6'd0, 1'b0);
      @(negedge clk); check("t2_ack", 32'(bus.o_ack), 32'h2);
      next_cycle(); bus.i_req = 4'b0000;
      next_cycle();
      @(negedge clk); check("t2_env_start", 32'(bus.o_envelope), 32'd64);
      check("t2_phase", bus.o_phase_delta, 32'h001CD5FA);
      for (int k = 1; k <= 8; k++) begin
         next_cycle(); bus.i_tick_stb = 1'b1;
         next_cycle(); bus.i_tick_stb = 1'b0;
         @(negedge clk);
         check($sformatf("t2_env_tick%0d", k), 32'(bus.o_envelope), 32'((2 - k / 4) * 32));
      end
      check("t2_busy_vol0", 32'(bus.o_busy), 32'h1);
      next_cycle();
      @(negedge clk); check("t2_done", 32'(bus.o_done), 32'h1);
      next_cycle();
      @(negedge clk); check("t2_idle_busy", 32'(bus.o_busy), 32'h0);

      // Preemption by a higher-priority requester
      next_cycle(); bus.i_req = 4'b0100; set_fields(2, 4'd0, 4'd15, 6'd0, 1'b1);
      @(negedge clk); check("t3_ack", 32'(bus.o_ack), 32'h4);
      next_cycle(); bus.i_req = 4'b0000;
      next_cycle();
      @(negedge clk); check("t3_env_max", 32'(bus.o_envelope), 32'd480);
      next_cycle(); bus.i_req = 4'b0001; set_fields(0, 4'd15, 4'd5, 6'd0, 1'b0);
      @(negedge clk); check("t3_preempt", 32'(bus.o_preempt), 32'h1);
      check("t3_ack0", 32'(bus.o_ack), 32'h1);
      check("t3_no_done", 32'(bus.o_done), 32'h0);
      next_cycle(); bus.i_req = 4'b0000;
      @(negedge clk); check("t3_id", 32'(bus.o_active_id), 32'h0);
      check("t3_load_valid", 32'(bus.o_phase_delta_valid), 32'h0);
      check("t3_load_done", 32'(bus.o_done), 32'h0);
      next_cycle();
      @(negedge clk); check("t3_phase", bus.o_phase_delta, 32'h001CD5FA);
      check("t3_env", 32'(bus.o_envelope), 32'd160);

      // Reset in mid-PLAY with a request held
      next_cycle(); rst = 1'b1; bus.i_req = 4'b0010; set_fields(1, 4'd0, 4'd1, 6'd1, 1'b0);
      @(negedge clk); check("t4_rst_ack", 32'(bus.o_ack), 32'h0);
      check("t4_rst_preempt", 32'(bus.o_preempt), 32'h0);
      check("t4_rst_done", 32'(bus.o_done), 32'h0);
      next_cycle(); rst = 1'b0;
      @(negedge clk); check("t4_busy", 32'(bus.o_busy), 32'h0);
      check("t4_env", 32'(bus.o_envelope), 32'h0);
      check("t4_phase", bus.o_phase_delta, 32'h0);
      check("t4_valid", 32'(bus.o_phase_delta_valid), 32'h0);
      check("t4_id", 32'(bus.o_active_id), 32'h0);
      check("t4_done", 32'(bus.o_done), 32'h0);
      check("t4_mode", 32'(bus.o_mode), 32'h0);
      check("t4_regrant", 32'(bus.o_ack), 32'h2);

      // Lower-priority request waits for RELEASE
      next_cycle(); bus.i_req = 4'b1000; set_fields(3, 4'd0, 4'd1, 6'd1, 1'b1);
      @(negedge clk); check("t5_load_ack", 32'(bus.o_ack), 32'h0);
      next_cycle(); bus.i_note_stb = 1'b1;
      @(negedge clk); check("t5_play_ack", 32'(bus.o_ack), 32'h0);
      check("t5_play_preempt", 32'(bus.o_preempt), 32'h0);
      check("t5_id", 32'(bus.o_active_id), 32'h1);
      next_cycle(); bus.i_note_stb = 1'b0;
      @(negedge clk); check("t5_len0_ack", 32'(bus.o_ack), 32'h0);
      next_cycle();
      @(negedge clk); check("t5_rel_done", 32'(bus.o_done), 32'h1);
      check("t5_rel_ack", 32'(bus.o_ack), 32'h0);
      next_cycle();
      @(negedge clk); check("t5_ack3", 32'(bus.o_ack), 32'h8);
      next_cycle(); bus.i_req = 4'b0000;
      next_cycle();
      @(negedge clk); check("t6_env_start", 32'(bus.o_envelope), 32'd32);
      check("t6_id", 32'(bus.o_active_id), 32'h3);

      // Tick and note coincide with volume and length both reaching 0
      for (int i = 0; i < 3; i++) begin
         next_cycle(); bus.i_tick_stb = 1'b1;
      end
      next_cycle(); bus.i_tick_stb = 1'b1; bus.i_note_stb = 1'b1;
      next_cycle(); bus.i_tick_stb = 1'b0; bus.i_note_stb = 1'b0;
      @(negedge clk); check("t6_env0", 32'(bus.o_envelope), 32'h0);
      check("t6_early_done", 32'(bus.o_done), 32'h0);
      done_count = 0;
      for (int j = 0; j < 4; j++) begin
         next_cycle();
         @(negedge clk);
         if (bus.o_done) done_count++;
      end
      check("t6_done_count", 32'(done_count), 32'd1);

      // Zero start volume goes straight through PLAY to RELEASE
      next_cycle(); bus.i_req = 4'b0001; set_fields(0, 4'd3, 4'd0, 6'd0, 1'b0);
      @(negedge clk); check("t7_ack", 32'(bus.o_ack), 32'h1);
      next_cycle(); bus.i_req = 4'b0000;
      next_cycle();
      @(negedge clk); check("t7_valid", 32'(bus.o_phase_delta_valid), 32'h1);
      check("t7_phase", bus.o_phase_delta, 32'h056A8F14);
      check("t7_play_done", 32'(bus.o_done), 32'h0);
      next_cycle();
      @(negedge clk); check("t7_done", 32'(bus.o_done), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
